// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the EX-stage divider.
//   div_state_e  - divider FSM encodings (DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END)
//   DIV_DATA_W   - operand width
//   DIV_RESULT_W - width of the {remainder, quotient} result
//   DIV_START/DIV_STOP - start_i levels driven by EX
package div_unit_pkg;

    localparam int unsigned DIV_DATA_W   = 32;
    localparam int unsigned DIV_RESULT_W = 64;

    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational radix-2 restoring step.
//   partial_i [2W:0] - partial register {upper, lower}; upper = remainder, lower = dividend/quotient
//   divisor_i [W-1:0] - unsigned divisor magnitude
//   partial_o [2W:0] - partial register after shift, trial subtract and quotient-bit insert
module div_unit_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2*DATA_W:0] partial_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [2*DATA_W:0] partial_o
);

    // Upper bits after the left shift, with one guard bit so the trial sign is exact.
    logic [DATA_W+1:0] upper;
    logic [DATA_W+1:0] trial;

    always_comb begin
        upper = partial_i[2*DATA_W:DATA_W-1];
        trial = upper - {2'b00, divisor_i};
        if (!trial[DATA_W+1]) begin
            partial_o = {trial[DATA_W:0], partial_i[DATA_W-2:0], 1'b1};
        end else begin
            partial_o = {upper[DATA_W:0], partial_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle signed/unsigned restoring divider for the EX stage.
//   clk, rst      - clock, synchronous active-high reset
//   signed_div_i  - 1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     - dividend; sampled with start_i
//   opdata2_i     - divisor; sampled with start_i
//   start_i       - request, held by EX until ready_o
//   annul_i       - abort (pipeline flush)
//   result_o      - {remainder, quotient}, valid while ready_o
//   ready_o       - result valid
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DIV_DATA_W,
    parameter int unsigned CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W:0]   partial_q, partial_d;
    logic [DATA_W-1:0]   divisor_q, divisor_d;
    logic                neg_rem_q, neg_rem_d;
    logic                neg_quo_q, neg_quo_d;
    logic                ready_q, ready_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic [2*DATA_W:0]   partial_step;
    logic [DATA_W-1:0]   dvd_abs, dvs_abs;
    logic [DATA_W-1:0]   quo_raw, rem_raw;

    div_unit_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .partial_i (partial_q),
        .divisor_i (divisor_q),
        .partial_o (partial_step)
    );

    // Magnitudes only differ from the raw operands for negative signed inputs;
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    assign dvd_abs = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign dvs_abs = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    assign quo_raw = partial_q[DATA_W-1:0];
    assign rem_raw = partial_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        partial_d = partial_q;
        divisor_d = divisor_q;
        neg_rem_d = neg_rem_q;
        neg_quo_d = neg_quo_q;
        ready_d   = ready_q;
        result_d  = result_q;

        if (annul_i) begin
            state_d  = DIV_IDLE;
            cnt_d    = '0;
            ready_d  = 1'b0;
            result_d = '0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        divisor_d = dvs_abs;
                        partial_d = {{(DATA_W+1){1'b0}}, dvd_abs};
                        neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
                        neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        cnt_d     = '0;
                        state_d   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                    end
                end
                DIV_BYZERO: begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
                DIV_ON: begin
                    if (cnt_q == CNT_W'(DATA_W)) begin
                        result_d = {neg_rem_q ? -rem_raw : rem_raw,
                                    neg_quo_q ? -quo_raw : quo_raw};
                        ready_d  = 1'b1;
                        state_d  = DIV_END;
                    end else begin
                        partial_d = partial_step;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        ready_d  = 1'b0;
                        result_d = '0;
                        state_d  = DIV_IDLE;
                    end
                end
                default: state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            partial_q <= '0;
            divisor_q <= '0;
            neg_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            ready_q   <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            partial_q <= partial_d;
            divisor_q <= divisor_d;
            neg_rem_q <= neg_rem_d;
            neg_quo_q <= neg_quo_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed self-checking bench for div_unit with an expected-result queue.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    div_unit #(
        .DATA_W (32),
        .CNT_W  (6)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one divide, wait for ready, compare against the queued expectation,
    // then exercise the hold-while-start and release behaviour.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expv, input int exp_lat);
        int lat;
        logic [63:0] want;
        signed_div = sgn;
        op1 = a;
        op2 = b;
        start = 1'b1;
        sb_q.push_back(expv);
        tick();
        // Operand changes after the start edge must be ignored.
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~sgn;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " ready"}, 64'(ready), 64'd1);
        want = sb_q.pop_front();
        chk({tag, " result"}, result, want);
        tick();
        chk({tag, " hold ready"}, 64'(ready), 64'd1);
        chk({tag, " hold result"}, result, want);
        start = 1'b0;
        tick();
        chk({tag, " release ready"}, 64'(ready), 64'd0);
        chk({tag, " release result"}, result, 64'd0);
        tick();
    endtask

    initial begin
        int seen;

        // Reset
        tick();
        tick();
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset result", result, 64'd0);
        rst = 1'b0;
        tick();
        chk("idle ready", 64'(ready), 64'd0);

        run_div("u100/7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33);
        run_div("s-7/2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
        run_div("s/0", 1'b1, 32'h12345678, 32'h0, 64'h0, 1);
        run_div("uFFFF/1", 1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 33);
        run_div("s ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
        run_div("s100/-7", 1'b1, 32'd100, 32'hFFFFFFF9, 64'h00000002_FFFFFFF2, 33);
        run_div("s-100/7", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 33);
        run_div("u big", 1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33);

        // Annul in the middle of a divide
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        tick();
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        tick();
        annul = 1'b0;
        chk("annul ready", 64'(ready), 64'd0);
        chk("annul result", result, 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (ready !== 1'b0) seen++;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        run_div("u9/3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

        // Annul together with start in IDLE: no divide starts
        op1 = 32'd50;
        op2 = 32'd5;
        start = 1'b1;
        annul = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        annul = 1'b0;
        seen = 0;
        repeat (40) begin
            tick();
            if (ready !== 1'b0) seen++;
        end
        chk("annul+start no ready", 64'(seen), 64'd0);

        // Reset in the middle of a divide
        op1 = 32'd77;
        op2 = 32'd5;
        start = 1'b1;
        tick();
        repeat (20) tick();
        rst = 1'b1;
        start = 1'b0;
        tick();
        chk("mid rst ready", 64'(ready), 64'd0);
        chk("mid rst result", result, 64'd0);
        rst = 1'b0;
        tick();
        run_div("after rst", 1'b0, 32'd77, 32'd5, 64'h00000002_0000000F, 33);

        chk("scoreboard empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned radix-2 restoring divider for the EX stage of the 5-stage pipeline.
- Produces the {remainder, quotient} pair that EX writes into HI/LO.
- While a divide is in flight, EX holds a stall request, and the ex/mem/wb-to-id forwarding buses carry no div result until ready_o.
- Start/ready handshake; annul kills an in-flight divide on flush.

Parameters:
- DATA_W, 32, operand width; quotient and remainder are each DATA_W bits.
- CNT_W, 6, iteration counter width; must hold the value DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i
- opdata1_i  input  32  dividend; sampled with start_i
- opdata2_i  input  32  divisor; sampled with start_i
- start_i  input  1  request; held high by EX until ready_o is seen
- annul_i  input  1  abort the current divide (pipeline flush)
- result_o  output  64  {remainder[31:0], quotient[31:0]}; valid only while ready_o = 1
- ready_o  output  1  result valid

Behaviour:
- Reset: state = IDLE, cnt = 0, ready_o = 0, result_o = 0, internal shift register = 0. Reset overrides every other input, including during ON.
- States:
  - IDLE, on start_i = 1 and annul_i = 0:
    - if opdata2_i == 0, go to BYZERO;
    - otherwise go to ON with cnt = 0.
    - Operands are latched: absolute values when signed_div_i = 1, raw values otherwise.
    - Sign flags are latched: dividend sign and (dividend sign XOR divisor sign).
    - The 65-bit partial register is loaded with {33'b0, |dividend|}.
  - BYZERO: next edge goes to END, result_o = 0, ready_o = 1.
  - ON, with annul_i = 0 and cnt < 32, on each edge:
    - shift the partial register left by 1;
    - trial = upper33 − {1'b0, |divisor|};
    - if trial is non-negative, replace upper33 with trial and set the quotient LSB to 1; otherwise set it to 0;
    - cnt += 1.
  - ON, with cnt == 32:
    - quotient = negated if the XOR flag is set (signed only);
    - remainder = negated if the dividend sign is set (signed only);
    - result_o = {remainder, quotient}, ready_o = 1, go to END.
  - ON, with annul_i = 1: go to IDLE, cnt = 0, ready_o stays 0, and no result is produced.
  - END: ready_o and result_o are held while start_i = 1. When start_i = 0, go to IDLE with ready_o = 0 and result_o = 0.
- annul_i in IDLE, BYZERO or END: forces IDLE, ready_o = 0, result_o = 0. annul_i together with start_i in IDLE: annul wins and no divide starts.
- Latency, with edge 0 sampling start_i:
  - normal divide: ready_o = 1 after edge 33 (32 iteration edges plus 1 fixup edge);
  - divide by zero: ready_o = 1 after edge 1.
- Arithmetic is modulo 2^32. 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000 and remainder 0, with no trap.
- Quotient rounds toward zero; the remainder takes the dividend's sign (MIPS semantics).
- Operands are not re-sampled after start; changes on opdata*_i during ON are ignored.
- Back-to-back use: a new start_i is accepted only in IDLE, so at least one start_i = 0 cycle is needed after END.

Decomposition:
- Shared package (or defines.vh) holds:
  - state encodings DIV_IDLE/DIV_BYZERO/DIV_ON/DIV_END;
  - DIV_RESULT_W = 64;
  - the DIV_START/DIV_STOP handshake constants used by EX.
- Optional sub-module div_step: combinational 33-bit trial subtract and shift, reused by a future multiplier-iteration block.
- The FSM, counter and sign fixup stay in div_unit.

Test Plan:
- Unsigned 100 / 7:
  - ready_o rises 33 cycles after start;
  - result_o = 0x00000002_0000000E;
  - ready_o held until start_i drops, then result_o = 0 the cycle after.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002): result_o = 0xFFFFFFFF_FFFFFFFD (remainder −1, quotient −3).
- Divide by zero, signed 0x12345678 / 0: ready_o after 1 cycle with result_o = 0. Unsigned 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result_o = 0x00000000_80000000 at 33 cycles.
- Annul on cycle 10 of ON:
  - state returns to IDLE and ready_o never rises;
  - a following start with 9 / 3 returns 0x00000000_00000003 after 33 cycles.
- rst asserted on cycle 20 of ON: next cycle ready_o = 0 and result_o = 0; a new start after rst deasserts completes normally.
